// File: rtl/md_if.sv
// ---------------------------------------------------------------------------
// md_if : request/result bundle between the EX stage and the multiply/divide
//         unit.
//   Start  1   one-cycle request, Op/A/B sampled on the same edge
//   Flush  1   cancel the in-flight operation
//   Op     4   operation code
//   A      32  rs operand
//   B      32  rt operand
//   Busy   1   long operation in flight
//   HI     32  HI register
//   LO     32  LO register
// master: pipeline side (drives the request); slave: md_unit.
// ---------------------------------------------------------------------------
interface md_if;
   logic        Start;
   logic        Flush;
   logic [3:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, Flush, Op, A, B,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, Flush, Op, A, B,
      output Busy, HI, LO
   );
endinterface

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit with HI/LO registers.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of md_if (Start/Flush/Op/A/B in; Busy/HI/LO out)
// Parameter MULT_CYCLES (1..31): Busy cycles for multiply-class operations.
// Divide takes 32 cycles (one restoring quotient bit per cycle).
// Optional feature macro MD_UNIT_MADD_EN: when defined, ops 1000..1011
// accumulate the product into {HI,LO}; when undefined they are no-ops.
// HI/LO only change on MTHI/MTLO acceptance or on the final edge of a long op.
// ---------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst_n,
   md_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10
   } state_t;

   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_MTHI  = 4'b0100;
   localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MD_UNIT_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'b1000;
   localparam logic [3:0] OP_MADDU = 4'b1001;
   localparam logic [3:0] OP_MSUB  = 4'b1010;
   localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

   localparam logic [5:0] MUL_LAST = 6'(MULT_CYCLES);
   localparam logic [5:0] DIV_LAST = 6'd32;

   // Magnitude of a 32-bit operand, treating it as signed only when sgn is set.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      logic [31:0] r;
      if (sgn && v[31]) begin
         r = 32'd0 - v;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  cnt_q,   cnt_d;
   logic        busy_q,  busy_d;
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;
   logic [31:0] a_q,     a_d;    // raw operands, kept for sign fix-up and B=0
   logic [31:0] b_q,     b_d;
   logic        sgn_q,   sgn_d;  // signed flavour of the latched op
   logic [31:0] rem_q,   rem_d;  // partial remainder
   logic [31:0] quo_q,   quo_d;  // dividend shifts out, quotient shifts in
`ifdef MD_UNIT_MADD_EN
   logic        acc_q,   acc_d;  // accumulate into {HI,LO}
   logic        sub_q,   sub_d;  // subtract rather than add
`endif

   logic        start_ok_s;
   logic [63:0] prod_s;
   logic [63:0] mul_res_s;
   logic [31:0] dvs_s;
   logic [32:0] rem_sh_s;
   logic [32:0] diff_s;
   logic        qbit_s;
   logic [31:0] rem_nx_s;
   logic [31:0] quo_nx_s;
   logic [31:0] div_hi_s;
   logic [31:0] div_lo_s;

   assign start_ok_s = bus.Start & ~bus.Flush & ~busy_q;

   // 64-bit product of the latched operands, signed or unsigned.
   always_comb begin
      if (sgn_q) begin
         prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
      end else begin
         prod_s = {32'd0, a_q} * {32'd0, b_q};
      end
   end

   // Multiply-class write-back value: plain product or {HI,LO} +/- product.
   always_comb begin
      mul_res_s = prod_s;
`ifdef MD_UNIT_MADD_EN
      if (acc_q) begin
         if (sub_q) begin
            mul_res_s = {hi_q, lo_q} - prod_s;
         end else begin
            mul_res_s = {hi_q, lo_q} + prod_s;
         end
      end else begin
         mul_res_s = prod_s;
      end
`endif
   end

   // One restoring-division step: shift in the next dividend bit, trial subtract.
   always_comb begin
      dvs_s    = abs32(b_q, sgn_q);
      rem_sh_s = {rem_q, quo_q[31]};
      diff_s   = rem_sh_s - {1'b0, dvs_s};
      qbit_s   = ~diff_s[32];
      if (qbit_s) begin
         rem_nx_s = diff_s[31:0];
      end else begin
         rem_nx_s = rem_sh_s[31:0];
      end
      quo_nx_s = {quo_q[30:0], qbit_s};
   end

   // Final divide result: divide-by-zero convention, else sign fix-up.
   // The quotient is negative when operand signs differ; the remainder
   // follows the dividend.
   always_comb begin
      if (b_q == 32'd0) begin
         div_lo_s = 32'hFFFF_FFFF;
         div_hi_s = a_q;
      end else begin
         if (sgn_q && (a_q[31] ^ b_q[31])) begin
            div_lo_s = 32'd0 - quo_nx_s;
         end else begin
            div_lo_s = quo_nx_s;
         end
         if (sgn_q && a_q[31]) begin
            div_hi_s = 32'd0 - rem_nx_s;
         end else begin
            div_hi_s = rem_nx_s;
         end
      end
   end

   // Next-state and datapath register update for the IDLE/MUL/DIV sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
`ifdef MD_UNIT_MADD_EN
      acc_d   = acc_q;
      sub_d   = sub_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) begin
               case (bus.Op)
                  OP_MULT, OP_MULTU: begin
                     state_d = ST_MUL;
                     cnt_d   = 6'd1;
                     busy_d  = 1'b1;
                     a_d     = bus.A;
                     b_d     = bus.B;
                     sgn_d   = ~bus.Op[0];
`ifdef MD_UNIT_MADD_EN
                     acc_d   = 1'b0;
                     sub_d   = 1'b0;
`endif
                  end
`ifdef MD_UNIT_MADD_EN
                  OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     state_d = ST_MUL;
                     cnt_d   = 6'd1;
                     busy_d  = 1'b1;
                     a_d     = bus.A;
                     b_d     = bus.B;
                     sgn_d   = ~bus.Op[0];
                     acc_d   = 1'b1;
                     sub_d   = bus.Op[1];
                  end
`endif
                  OP_DIV, OP_DIVU: begin
                     state_d = ST_DIV;
                     cnt_d   = 6'd1;
                     busy_d  = 1'b1;
                     a_d     = bus.A;
                     b_d     = bus.B;
                     sgn_d   = ~bus.Op[0];
                     rem_d   = 32'd0;
                     quo_d   = abs32(bus.A, ~bus.Op[0]);
                  end
                  OP_MTHI: begin
                     hi_d = bus.A;
                  end
                  OP_MTLO: begin
                     lo_d = bus.A;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (bus.Flush) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 6'd0;
            end else if (cnt_q == MUL_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 6'd0;
               hi_d    = mul_res_s[63:32];
               lo_d    = mul_res_s[31:0];
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DIV: begin
            if (bus.Flush) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 6'd0;
            end else if (cnt_q == DIV_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 6'd0;
               hi_d    = div_hi_s;
               lo_d    = div_lo_s;
            end else begin
               cnt_d = cnt_q + 6'd1;
               rem_d = rem_nx_s;
               quo_d = quo_nx_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // State and datapath registers; reset clears everything, aborting any op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
`ifdef MD_UNIT_MADD_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
`ifdef MD_UNIT_MADD_EN
         acc_q   <= acc_d;
         sub_q   <= sub_d;
`endif
      end
   end

   assign bus.Busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and Busy length
// from a reference model; a monitor pops on each Busy fall or MTHI/MTLO probe.
module tb_md_unit;
   localparam int MC = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   md_if bus ();

   md_unit #(.MULT_CYCLES(MC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        probe = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [3:0]  ops_tab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8,
                                 4'h9, 4'hA, 4'hB, 4'h6, 4'h7, 4'hC, 4'hF};

   logic        prev_busy = 1'b0;
   int          bcnt = 0;
   bit          stable = 1'b1;
   logic [31:0] h0, l0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: architectural effect of one accepted op on m_hi/m_lo.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      logic [63:0] p, acc;
      longint sa, sbv, q, r;
      cyc = 0;
      case (op)
         4'h0: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            {m_hi, m_lo} = p; cyc = MC;
         end
         4'h1: begin
            p = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = p; cyc = MC;
         end
         4'h2: begin
            cyc = 32;
            if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin
               sa = longint'($signed(a)); sbv = longint'($signed(b));
               q = sa / sbv; r = sa % sbv;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
         end
         4'h3: begin
            cyc = 32;
            if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
         4'h4: m_hi = a;
         4'h5: m_lo = a;
         4'h8, 4'h9, 4'hA, 4'hB: begin
`ifdef MD_UNIT_MADD_EN
            if (op[0]) p = {32'd0, a} * {32'd0, b};
            else       p = 64'(longint'($signed(a)) * longint'($signed(b)));
            acc = {m_hi, m_lo};
            acc = op[1] ? acc - p : acc + p;
            {m_hi, m_lo} = acc; cyc = MC;
`else
            cyc = 0;
`endif
         end
         default: cyc = 0;
      endcase
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL wait_timeout pending=%0d expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic push(input string nm, input int cyc);
      exp_t e;
      e.hi = m_hi; e.lo = m_lo; e.cyc = cyc; e.name = nm;
      sb.push_back(e);
   endtask

   // Issue one op; optionally pulse an ignored Start while the op is busy.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string nm, input bit poke);
      int cyc;
      @(negedge clk);
      bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
      @(negedge clk);
      bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      model(op, a, b, cyc);
      push(nm, cyc);
      if (cyc == 0) begin
         probe = 1'b1;
         @(negedge clk);
         probe = 1'b0;
      end else if (poke) begin
         @(negedge clk);
         bus.Start = 1'b1; bus.Op = 4'($urandom_range(0, 5));
         bus.A = $urandom; bus.B = $urandom;
         @(negedge clk);
         bus.Start = 1'b0;
      end
      wait_empty();
   endtask

   // Long op cut short at cycle 10 by Flush (use_rst=0) or by rst_n (use_rst=1).
   task automatic abort_div(input bit use_rst, input string nm);
      @(negedge clk);
      bus.Start = 1'b1; bus.Op = 4'h2; bus.A = $urandom; bus.B = 32'd3;
      @(negedge clk);
      bus.Start = 1'b0;
      if (use_rst) begin m_hi = 32'd0; m_lo = 32'd0; end
      push(nm, 10);
      repeat (9) @(negedge clk);
      if (use_rst) rst_n = 1'b0; else bus.Flush = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; bus.Flush = 1'b0;
      wait_empty();
   endtask

   // Monitor: counts Busy cycles, checks HI/LO stability, pops on each result event.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.Busy) begin
            if (!prev_busy) begin
               h0 = bus.HI; l0 = bus.LO; stable = 1'b1;
            end else if (bus.HI !== h0 || bus.LO !== l0) begin
               stable = 1'b0;
            end
            bcnt++;
         end
         if ((prev_busy && !bus.Busy) || probe) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_event busy=%b probe=%b", bus.Busy, probe);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_hi"}, 64'(bus.HI), 64'(e.hi));
               chk({e.name, "_lo"}, 64'(bus.LO), 64'(e.lo));
               chk({e.name, "_busy_cycles"}, 64'(bcnt), 64'(e.cyc));
               if (e.cyc > 0) chk({e.name, "_stable"}, 64'(stable), 64'd1);
            end
            bcnt = 0;
         end
         prev_busy = bus.Busy;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      bus.Start = 1'b0; bus.Flush = 1'b0; bus.Op = 4'h0; bus.A = 32'd0; bus.B = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_hi",   64'(bus.HI),   64'd0);
      chk("reset_lo",   64'(bus.LO),   64'd0);
      chk("reset_busy", 64'(bus.Busy), 64'd0);
      rst_n = 1'b1;

      issue(4'h4, 32'h1234_5678, 32'd0, "mthi", 1'b0);
      issue(4'h0, 32'hFFFF_FFFE, 32'd3, "mult", 1'b0);
      issue(4'h1, 32'hFFFF_FFFE, 32'd3, "multu", 1'b1);
      issue(4'h2, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
      issue(4'h2, 32'd7, 32'hFFFF_FFFE, "div_negb", 1'b0);
      issue(4'h3, 32'd7, 32'd0, "divu_zero", 1'b0);
      issue(4'h2, 32'hFFFF_FFF9, 32'd0, "div_zero", 1'b0);
      issue(4'h2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
      issue(4'h3, 32'hFFFF_FFFF, 32'd16, "divu", 1'b0);

      // Start together with Flush is ignored.
      @(negedge clk);
      bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 4'h4; bus.A = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.Start = 1'b0; bus.Flush = 1'b0;
      push("start_flush", 0);
      probe = 1'b1;
      @(negedge clk);
      probe = 1'b0;
      wait_empty();

      issue(4'h4, 32'h1111_1111, 32'd0, "pre_hi", 1'b0);
      issue(4'h5, 32'h1111_1111, 32'd0, "pre_lo", 1'b0);
      abort_div(1'b0, "flush_div");
      abort_div(1'b1, "reset_div");

      issue(4'h4, 32'd0, 32'd0, "madd_pre_hi", 1'b0);
      issue(4'h5, 32'hFFFF_FFFF, 32'd0, "madd_pre_lo", 1'b0);
      issue(4'h9, 32'd1, 32'd1, "maddu", 1'b0);
      issue(4'hA, 32'hFFFF_FFFD, 32'd5, "msub", 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop = ops_tab[$urandom_range(0, 13)];
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 9));
            3: rb = 32'd0 - 32'($urandom_range(1, 9));
            default: ;
         endcase
         issue(rop, ra, rb, "rand", 1'($urandom_range(0, 1)));
      end

      wait_empty();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
